reg_dump_reader: RTL

Sequential reader for the register file's debug read port (debug_addr / debug_data_reg). On a start pulse it scans a configurable register range, capturing one register per step. Each captured word goes out on a valid/ready stream for the display, UART or trace logic. It sits beside the CPU core and never touches the register file's architectural ports.

---
 rtl/reg_dump_reader_if.sv | 25 ++
 rtl/reg_dump_reader.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader_if.sv
// Valid/ready stream carrying captured register words.
// master = reader, slave = display/UART/trace consumer.
interface reg_dump_reader_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Scans a register range via the debug read port and streams each word.
// Define REG_DUMP_CKSUM_EN to append a trailing XOR checksum beat.
module reg_dump_reader #(
  parameter int FIRST_REG  = 0,
  parameter int LAST_REG   = 31,
  parameter int SETTLE_CYC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  debug_addr,
  input  logic [31:0] debug_data_reg,
  reg_dump_reader_if.master dump,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST  = 5'(FIRST_REG);
  localparam logic [4:0] LAST   = 5'(LAST_REG);
  localparam logic [3:0] SETTLE = 4'(SETTLE_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ST_SET = 2'd1,
`ifdef REG_DUMP_CKSUM_EN
    SEND   = 2'd2,
    CKSUM  = 2'd3
`else
    SEND   = 2'd2
`endif
  } state_t;

  state_t      state, state_n;
  logic [4:0]  addr_r, addr_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] data_r, data_n;
  logic [4:0]  index_r, index_n;
  logic        valid_r, valid_n;
  logic        done_r, done_n;
`ifdef REG_DUMP_CKSUM_EN
  logic [31:0] cksum, cksum_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_r  <= '0;
      cnt     <= '0;
      data_r  <= '0;
      index_r <= '0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
`ifdef REG_DUMP_CKSUM_EN
      cksum   <= '0;
`endif
    end else begin
      state   <= state_n;
      addr_r  <= addr_n;
      cnt     <= cnt_n;
      data_r  <= data_n;
      index_r <= index_n;
      valid_r <= valid_n;
      done_r  <= done_n;
`ifdef REG_DUMP_CKSUM_EN
      cksum   <= cksum_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr_r;
    cnt_n   = cnt;
    data_n  = data_r;
    index_n = index_r;
    valid_n = valid_r;
    done_n  = 1'b0;
`ifdef REG_DUMP_CKSUM_EN
    cksum_n = cksum;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          addr_n  = FIRST;
          cnt_n   = SETTLE;
          state_n = ST_SET;
`ifdef REG_DUMP_CKSUM_EN
          cksum_n = '0;
`endif
        end
      end
      ST_SET: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          data_n  = debug_data_reg;
          index_n = addr_r;
          valid_n = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        if (dump.out_ready) begin
          valid_n = 1'b0;
`ifdef REG_DUMP_CKSUM_EN
          cksum_n = cksum ^ data_r;
`endif
          if (addr_r != LAST) begin
            addr_n  = addr_r + 5'd1;
            cnt_n   = SETTLE;
            state_n = ST_SET;
          end else begin
`ifdef REG_DUMP_CKSUM_EN
            data_n  = cksum ^ data_r;
            index_n = LAST;
            valid_n = 1'b1;
            state_n = CKSUM;
`else
            done_n  = 1'b1;
            state_n = IDLE;
`endif
          end
        end
      end
`ifdef REG_DUMP_CKSUM_EN
      CKSUM: begin
        if (dump.out_ready) begin
          valid_n = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
`endif
    endcase
    // abort wins over any handshake in flight
    if (abort && state != IDLE) begin
      state_n = IDLE;
      valid_n = 1'b0;
      done_n  = 1'b0;
    end
  end

  assign debug_addr     = addr_r;
  assign dump.out_valid = valid_r;
  assign dump.out_data  = data_r;
  assign dump.out_index = index_r;
`ifdef REG_DUMP_CKSUM_EN
  assign dump.out_last  = (state == CKSUM);
`else
  assign dump.out_last  = (state == SEND) && (addr_r == LAST);
`endif
  assign busy = (state != IDLE);
  assign done = done_r;

endmodule
